rs_age_issue_queue: RTL and testbench

Parametrised out-of-order issue queue that succeeds the fixed four-port reservation station. It allocates free entries itself and accepts `DISP_W` dispatches per cycle. It snoops `CDB_W` result buses for operand wakeup and grants up to `ISSUE_W` ready entries per cycle, oldest first, tracked by an age matrix. It sits between rename/dispatch and the ALU cluster; each issue port drives one execution unit through a valid/ready handshake.

---
 rtl/rs_age_issue_queue.sv | 168 ++++++++++++++++
 tb/tb_rs_age_issue_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_issue_queue.sv
// rs_age_issue_queue: multi-lane dispatch, CDB wakeup, oldest-first multi-port issue queue
module rs_age_issue_queue #(
  parameter int RS_DEPTH = 8,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 6,
  parameter int OP_W     = 32,
  parameter int CDB_W    = 4,
  parameter int DISP_W   = 2,
  parameter int ISSUE_W  = 2,
  parameter int CNT_W    = $clog2(RS_DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [DISP_W-1:0]         disp_valid_i,
  output logic                      disp_ready_o,
  input  logic [DISP_W*OP_W-1:0]    disp_op_i,
  input  logic [DISP_W*TAG_W-1:0]   disp_dst_tag_i,
  input  logic [DISP_W*DATA_W-1:0]  disp_v1_i,
  input  logic [DISP_W*DATA_W-1:0]  disp_v2_i,
  input  logic [DISP_W*TAG_W-1:0]   disp_q1_i,
  input  logic [DISP_W*TAG_W-1:0]   disp_q2_i,
  input  logic [DISP_W-1:0]         disp_r1_i,
  input  logic [DISP_W-1:0]         disp_r2_i,
  input  logic [CDB_W-1:0]          cdb_valid_i,
  input  logic [CDB_W*TAG_W-1:0]    cdb_tag_i,
  input  logic [CDB_W*DATA_W-1:0]   cdb_value_i,
  output logic [ISSUE_W-1:0]        iss_valid_o,
  input  logic [ISSUE_W-1:0]        iss_ready_i,
  output logic [ISSUE_W*OP_W-1:0]   iss_op_o,
  output logic [ISSUE_W*TAG_W-1:0]  iss_dst_tag_o,
  output logic [ISSUE_W*DATA_W-1:0] iss_v1_o,
  output logic [ISSUE_W*DATA_W-1:0] iss_v2_o,
  output logic [RS_DEPTH-1:0]       busy_o,
  output logic [CNT_W-1:0]          free_count_o
);
  localparam int IDX_W = RS_DEPTH > 1 ? $clog2(RS_DEPTH) : 1;
  logic [RS_DEPTH-1:0] busy_q, busy_d, r1_q, r1_d, r2_q, r2_d, rdy;
  logic [RS_DEPTH-1:0][OP_W-1:0] op_q, op_d;
  logic [RS_DEPTH-1:0][TAG_W-1:0] dst_q, dst_d, q1_q, q1_d, q2_q, q2_d;
  logic [RS_DEPTH-1:0][DATA_W-1:0] v1_q, v1_d, v2_q, v2_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
  logic [ISSUE_W-1:0][IDX_W-1:0] sel;
  logic [CNT_W-1:0] used;

  assign rdy = busy_q & r1_q & r2_q;
  assign busy_o = busy_q;
  assign free_count_o = CNT_W'(RS_DEPTH) - used;
  assign disp_ready_o = int'(free_count_o) >= DISP_W;

  // occupancy popcount over registered busy bits
  always_comb begin
    used = '0;
    for (int i = 0; i < RS_DEPTH; i++) used = used + CNT_W'(busy_q[i]);
  end

  // rank each ready entry by how many ready entries are older; rank p drives port p
  always_comb begin : select
    int rank;
    iss_valid_o = '0;
    sel = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      rank = 0;
      for (int j = 0; j < RS_DEPTH; j++) if (j != i && rdy[j] && age_q[j][i]) rank++;
      for (int p = 0; p < ISSUE_W; p++)
        if (rdy[i] && rank == p) begin
          iss_valid_o[p] = !flush_i;
          sel[p] = IDX_W'(i);
        end
    end
    for (int p = 0; p < ISSUE_W; p++) begin
      iss_op_o[p*OP_W +: OP_W] = op_q[sel[p]];
      iss_dst_tag_o[p*TAG_W +: TAG_W] = dst_q[sel[p]];
      iss_v1_o[p*DATA_W +: DATA_W] = v1_q[sel[p]];
      iss_v2_o[p*DATA_W +: DATA_W] = v2_q[sel[p]];
    end
  end

  // wakeup, issue release, in-order lane allocation with age update, flush
  always_comb begin : next_state
    logic [RS_DEPTH-1:0] older;
    int idx;
    busy_d = busy_q;
    r1_d = r1_q;
    r2_d = r2_q;
    op_d = op_q;
    dst_d = dst_q;
    q1_d = q1_q;
    q2_d = q2_q;
    v1_d = v1_q;
    v2_d = v2_q;
    age_d = age_q;
    older = busy_q;
    idx = 0;
    for (int i = 0; i < RS_DEPTH; i++)
      for (int c = 0; c < CDB_W; c++)
        if (busy_q[i] && cdb_valid_i[c]) begin
          if (!r1_q[i] && cdb_tag_i[c*TAG_W +: TAG_W] == q1_q[i]) begin
            v1_d[i] = cdb_value_i[c*DATA_W +: DATA_W];
            r1_d[i] = 1'b1;
          end
          if (!r2_q[i] && cdb_tag_i[c*TAG_W +: TAG_W] == q2_q[i]) begin
            v2_d[i] = cdb_value_i[c*DATA_W +: DATA_W];
            r2_d[i] = 1'b1;
          end
        end
    for (int p = 0; p < ISSUE_W; p++) if (iss_valid_o[p] && iss_ready_i[p]) busy_d[sel[p]] = 1'b0;
    if (disp_ready_o && !flush_i)
      for (int l = 0; l < DISP_W; l++)
        if (disp_valid_i[l]) begin
          idx = 0;
          for (int i = RS_DEPTH-1; i >= 0; i--) if (!older[i]) idx = i;
          busy_d[idx] = 1'b1;
          op_d[idx] = disp_op_i[l*OP_W +: OP_W];
          dst_d[idx] = disp_dst_tag_i[l*TAG_W +: TAG_W];
          q1_d[idx] = disp_q1_i[l*TAG_W +: TAG_W];
          q2_d[idx] = disp_q2_i[l*TAG_W +: TAG_W];
          v1_d[idx] = disp_v1_i[l*DATA_W +: DATA_W];
          v2_d[idx] = disp_v2_i[l*DATA_W +: DATA_W];
          r1_d[idx] = disp_r1_i[l];
          r2_d[idx] = disp_r2_i[l];
          for (int c = 0; c < CDB_W; c++)
            if (cdb_valid_i[c]) begin
              if (!disp_r1_i[l] && cdb_tag_i[c*TAG_W +: TAG_W] == disp_q1_i[l*TAG_W +: TAG_W]) begin
                v1_d[idx] = cdb_value_i[c*DATA_W +: DATA_W];
                r1_d[idx] = 1'b1;
              end
              if (!disp_r2_i[l] && cdb_tag_i[c*TAG_W +: TAG_W] == disp_q2_i[l*TAG_W +: TAG_W]) begin
                v2_d[idx] = cdb_value_i[c*DATA_W +: DATA_W];
                r2_d[idx] = 1'b1;
              end
            end
          age_d[idx] = '0;
          for (int j = 0; j < RS_DEPTH; j++) age_d[j][idx] = older[j];
          older[idx] = 1'b1;
        end
    if (flush_i) begin
      busy_d = '0;
      age_d = '0;
    end
  end

  // entry state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      op_q <= '0;
      dst_q <= '0;
      q1_q <= '0;
      q2_q <= '0;
      v1_q <= '0;
      v2_q <= '0;
      age_q <= '0;
    end else begin
      busy_q <= busy_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      op_q <= op_d;
      dst_q <= dst_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      age_q <= age_d;
    end
endmodule

// File: tb/tb_rs_age_issue_queue.sv
// tb_rs_age_issue_queue: directed stimulus with an age-ordered list model checked every cycle
module tb_rs_age_issue_queue;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [1:0] dv = '0, dr1 = '0, dr2 = '0, ir = '0;
  logic [63:0] dop = '0, dv1 = '0, dv2 = '0;
  logic [11:0] ddst = '0, dq1 = '0, dq2 = '0;
  logic [3:0] cv = '0;
  logic [23:0] ct = '0;
  logic [127:0] cval = '0;
  logic disp_ready;
  logic [1:0] iv;
  logic [63:0] iop, iv1, iv2;
  logic [11:0] idst;
  logic [7:0] busy;
  logic [3:0] fc;
  int n_chk = 0, n_fail = 0;

  rs_age_issue_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .disp_valid_i(dv), .disp_ready_o(disp_ready), .disp_op_i(dop), .disp_dst_tag_i(ddst),
    .disp_v1_i(dv1), .disp_v2_i(dv2), .disp_q1_i(dq1), .disp_q2_i(dq2),
    .disp_r1_i(dr1), .disp_r2_i(dr2),
    .cdb_valid_i(cv), .cdb_tag_i(ct), .cdb_value_i(cval),
    .iss_valid_o(iv), .iss_ready_i(ir), .iss_op_o(iop), .iss_dst_tag_o(idst),
    .iss_v1_o(iv1), .iss_v2_o(iv2), .busy_o(busy), .free_count_o(fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op, v1, v2;
    logic [5:0] dst, q1, q2;
    logic r1, r2;
    int slot;
  } ent_t;

  ent_t m[$], nm[$];
  int rl[$];
  ent_t e;
  logic [7:0] bm, gone;
  logic [32:0] w;
  int s;

  task automatic check(input string nm_s, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm_s, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] wake(input logic r, input logic [5:0] q, input logic [31:0] v);
    logic [32:0] res = {r, v};
    for (int c = 0; c < 4; c++) if (!r && cv[c] && ct[c*6 +: 6] == q) res = {1'b1, cval[c*32 +: 32]};
    return res;
  endfunction

  // model: m holds live entries oldest first; compare, then advance to the next edge
  always @(negedge clk) begin
    if (rst) m.delete();
    rl.delete();
    bm = '0;
    foreach (m[k]) begin
      bm[m[k].slot] = 1'b1;
      if (m[k].r1 && m[k].r2) rl.push_back(k);
    end
    check("busy", 64'(busy), 64'(bm));
    check("free_count", 64'(fc), 64'(8 - m.size()));
    check("disp_ready", 64'(disp_ready), 64'(m.size() <= 6));
    for (int p = 0; p < 2; p++) begin
      check("iss_valid", 64'(iv[p]), 64'(!flush && rl.size() > p));
      if (!flush && rl.size() > p) begin
        e = m[rl[p]];
        check("iss_dst", 64'(idst[p*6 +: 6]), 64'(e.dst));
        check("iss_op", 64'(iop[p*32 +: 32]), 64'(e.op));
        check("iss_v1", 64'(iv1[p*32 +: 32]), 64'(e.v1));
        check("iss_v2", 64'(iv2[p*32 +: 32]), 64'(e.v2));
      end
    end
    if (!rst && flush) m.delete();
    else if (!rst) begin
      gone = '0;
      for (int p = 0; p < 2; p++) if (rl.size() > p && ir[p]) gone[m[rl[p]].slot] = 1'b1;
      nm.delete();
      foreach (m[k]) begin
        e = m[k];
        w = wake(e.r1, e.q1, e.v1);
        e.r1 = w[32];
        e.v1 = w[31:0];
        w = wake(e.r2, e.q2, e.v2);
        e.r2 = w[32];
        e.v2 = w[31:0];
        if (!gone[e.slot]) nm.push_back(e);
      end
      if (m.size() <= 6)
        for (int l = 0; l < 2; l++)
          if (dv[l]) begin
            s = 0;
            for (int t = 7; t >= 0; t--) if (!bm[t]) s = t;
            bm[s] = 1'b1;
            e.slot = s;
            e.op = dop[l*32 +: 32];
            e.dst = ddst[l*6 +: 6];
            e.q1 = dq1[l*6 +: 6];
            e.q2 = dq2[l*6 +: 6];
            w = wake(dr1[l], e.q1, dv1[l*32 +: 32]);
            e.r1 = w[32];
            e.v1 = w[31:0];
            w = wake(dr2[l], e.q2, dv2[l*32 +: 32]);
            e.r2 = w[32];
            e.v2 = w[31:0];
            nm.push_back(e);
          end
      m = nm;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dv = '0;
    cv = '0;
  endtask

  task automatic lane(input int l, input logic [5:0] dst, input logic [5:0] q1, input logic r1,
                      input logic [31:0] v1, input logic [5:0] q2, input logic r2, input logic [31:0] v2);
    dv[l] = 1'b1;
    dop[l*32 +: 32] = 32'hA000 + 32'(dst);
    ddst[l*6 +: 6] = dst;
    dq1[l*6 +: 6] = q1;
    dr1[l] = r1;
    dv1[l*32 +: 32] = v1;
    dq2[l*6 +: 6] = q2;
    dr2[l] = r2;
    dv2[l*32 +: 32] = v2;
  endtask

  task automatic bus(input int c, input logic [5:0] t, input logic [31:0] v);
    cv[c] = 1'b1;
    ct[c*6 +: 6] = t;
    cval[c*32 +: 32] = v;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_free", 64'(fc), 64'd8);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    check("rst_iss_valid", 64'(iv), 64'd0);
    // fill and oldest-first order
    lane(0, 1, 0, 1, 32'h100, 0, 1, 32'h200);
    lane(1, 2, 0, 1, 32'h101, 0, 1, 32'h201);
    tick();
    idle();
    lane(0, 3, 0, 1, 32'h102, 0, 1, 32'h202);
    lane(1, 4, 0, 1, 32'h103, 0, 1, 32'h203);
    tick();
    idle();
    #1;
    check("fill_busy", 64'(busy), 64'h0F);
    check("fill_free", 64'(fc), 64'd4);
    check("fill_valid", 64'(iv), 64'd3);
    check("fill_p0", 64'(idst[5:0]), 64'd1);
    check("fill_p1", 64'(idst[11:6]), 64'd2);
    ir = 2'b11;
    tick();
    #1;
    check("order_p0", 64'(idst[5:0]), 64'd3);
    check("order_p1", 64'(idst[11:6]), 64'd4);
    check("order_busy", 64'(busy), 64'h0C);
    tick();
    ir = 2'b00;
    #1;
    check("drain_busy", 64'(busy), 64'h0);
    // wakeup from CDB0
    lane(0, 10, 9, 0, 32'h0, 0, 1, 32'h22);
    tick();
    idle();
    bus(0, 9, 32'hDEAD);
    #1;
    check("wait_valid", 64'(iv), 64'd0);
    tick();
    idle();
    #1;
    check("wake_valid", 64'(iv), 64'd1);
    check("wake_v1", 64'(iv1[31:0]), 64'hDEAD);
    ir = 2'b01;
    tick();
    ir = 2'b00;
    // dispatch-time forward with two matching buses, highest index wins
    lane(0, 11, 0, 1, 32'h5, 5, 0, 32'h0);
    bus(1, 5, 32'h11);
    bus(3, 5, 32'h33);
    tick();
    idle();
    #1;
    check("fwd_valid", 64'(iv), 64'd1);
    check("fwd_v2", 64'(iv2[31:0]), 64'h33);
    ir = 2'b01;
    tick();
    ir = 2'b00;
    // full backpressure with seven busy entries
    lane(0, 30, 40, 0, 0, 0, 1, 1);
    lane(1, 31, 40, 0, 0, 0, 1, 1);
    tick();
    idle();
    lane(0, 32, 40, 0, 0, 0, 1, 1);
    lane(1, 33, 0, 1, 32'h33, 0, 1, 1);
    tick();
    idle();
    lane(0, 34, 40, 0, 0, 0, 1, 1);
    lane(1, 35, 40, 0, 0, 0, 1, 1);
    tick();
    idle();
    lane(0, 36, 40, 0, 0, 0, 1, 1);
    tick();
    idle();
    #1;
    check("full_busy", 64'(busy), 64'h7F);
    check("full_free", 64'(fc), 64'd1);
    check("full_ready", 64'(disp_ready), 64'd0);
    check("full_p0", 64'(idst[5:0]), 64'd33);
    lane(0, 50, 0, 1, 0, 0, 1, 0);
    tick();
    idle();
    #1;
    check("full_nowrite", 64'(busy), 64'h7F);
    ir = 2'b01;
    tick();
    ir = 2'b00;
    #1;
    check("freed_busy", 64'(busy), 64'h77);
    check("freed_free", 64'(fc), 64'd2);
    check("freed_ready", 64'(disp_ready), 64'd1);
    bus(0, 40, 32'h40);
    tick();
    idle();
    #1;
    check("woke6_valid", 64'(iv), 64'd3);
    check("woke6_p0", 64'(idst[5:0]), 64'd30);
    check("woke6_p1", 64'(idst[11:6]), 64'd31);
    // flush with a concurrent dispatch
    flush = 1'b1;
    lane(0, 60, 0, 1, 0, 0, 1, 0);
    lane(1, 61, 0, 1, 0, 0, 1, 0);
    #1;
    check("flush_valid", 64'(iv), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_free", 64'(fc), 64'd8);
    // age preemption: older A wakes and displaces younger B from port 0
    lane(0, 20, 7, 0, 0, 0, 1, 1);
    lane(1, 21, 0, 1, 2, 0, 1, 3);
    tick();
    idle();
    bus(0, 7, 32'h77);
    #1;
    check("pre_valid", 64'(iv), 64'd1);
    check("pre_p0", 64'(idst[5:0]), 64'd21);
    tick();
    idle();
    #1;
    check("age_valid", 64'(iv), 64'd3);
    check("age_p0", 64'(idst[5:0]), 64'd20);
    check("age_p1", 64'(idst[11:6]), 64'd21);
    check("age_v1", 64'(iv1[31:0]), 64'h77);
    ir = 2'b11;
    tick();
    ir = 2'b00;
    // asynchronous reset in the middle of a cycle
    lane(0, 1, 0, 1, 0, 0, 1, 0);
    lane(1, 2, 0, 1, 0, 0, 1, 0);
    tick();
    idle();
    #1;
    check("prerst_busy", 64'(busy), 64'h03);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_free", 64'(fc), 64'd8);
    check("arst_ready", 64'(disp_ready), 64'd1);
    check("arst_valid", 64'(iv), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
